// File: rtl/bram_fifo_pkg.sv
// rtl/bram_fifo_pkg.sv - geometry and flag thresholds shared by the block-RAM FIFO controllers
package bram_fifo_pkg;
   localparam int ADDR_W_S1        = 14;
   localparam int DEPTH_S1         = 1 << ADDR_W_S1;
   localparam int AFULL_THRESH_S1  = DEPTH_S1 - 4;
   localparam int AEMPTY_THRESH_S1 = 4;
endpackage

// File: rtl/bram_s1_fifo_ctrl_if.sv
// rtl/bram_s1_fifo_ctrl_if.sv - producer/consumer side of the 16Kx1 FIFO controller
interface bram_s1_fifo_ctrl_if
   import bram_fifo_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_S1
);
   logic              wr_en;
   logic              wr_data;
   logic              full;
   logic              afull;
   logic              wr_err;
   logic              rd_en;
   logic              rd_data;
   logic              rd_valid;
   logic              empty;
   logic              aempty;
   logic              rd_err;
   logic [ADDR_W:0]   count;

   modport master (
      output wr_en, wr_data, rd_en,
      input  full, afull, wr_err, rd_data, rd_valid, empty, aempty, rd_err, count
   );

   modport slave (
      input  wr_en, wr_data, rd_en,
      output full, afull, wr_err, rd_data, rd_valid, empty, aempty, rd_err, count
   );
endinterface

// File: rtl/bram_s1_fifo_ctrl.sv
// rtl/bram_s1_fifo_ctrl.sv - pointer, occupancy and flag logic in front of a RAMB16_S1_S1
// Port A writes, port B reads; the RAM primitive itself is instantiated by the parent.
module bram_s1_fifo_ctrl
   import bram_fifo_pkg::*;
#(
   parameter int ADDR_W        = ADDR_W_S1,
   parameter int AFULL_THRESH  = AFULL_THRESH_S1,
   parameter int AEMPTY_THRESH = AEMPTY_THRESH_S1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   bram_s1_fifo_ctrl_if.slave  fifo_if,
   output logic [ADDR_W-1:0]   ram_addra_o,
   output logic                ram_dia_o,
   output logic                ram_ena_o,
   output logic                ram_wea_o,
   output logic                ram_ssra_o,
   output logic [ADDR_W-1:0]   ram_addrb_o,
   output logic                ram_enb_o,
   output logic                ram_ssrb_o,
   input  logic                ram_dob_i
);
   localparam int CW = ADDR_W + 1;
   localparam logic [CW-1:0] DEPTH_C  = CW'(2 ** ADDR_W);
   localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
   localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              full_q, full_d, afull_q, afull_d;
   logic              empty_q, empty_d, aempty_q, aempty_d;
   logic              wr_err_q, wr_err_d, rd_err_q, rd_err_d;
   logic              rd_valid_q;
   logic              wr_acc, rd_acc;

   // No bypass: a full FIFO refuses writes even when a read drains it in the same cycle,
   // which also guarantees the two RAM ports never hit the same address together.
   assign wr_acc = fifo_if.wr_en & ~full_q;
   assign rd_acc = fifo_if.rd_en & ~empty_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Flags look at the next count so they are exact the cycle after the change.
   always_comb begin
      full_d   = (count_d == DEPTH_C);
      afull_d  = (count_d >= AFULL_C);
      empty_d  = (count_d == '0);
      aempty_d = (count_d <= AEMPTY_C);
      wr_err_d = wr_err_q | (fifo_if.wr_en & full_q);
      rd_err_d = rd_err_q | (fifo_if.rd_en & empty_q);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         afull_q    <= 1'b0;
         empty_q    <= 1'b1;
         aempty_q   <= 1'b1;
         wr_err_q   <= 1'b0;
         rd_err_q   <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         full_q     <= full_d;
         afull_q    <= afull_d;
         empty_q    <= empty_d;
         aempty_q   <= aempty_d;
         wr_err_q   <= wr_err_d;
         rd_err_q   <= rd_err_d;
         rd_valid_q <= rd_acc;
      end
   end

   assign ram_addra_o = wr_ptr_q;
   assign ram_dia_o   = fifo_if.wr_data;
   assign ram_ena_o   = wr_acc & ~rst_i;
   assign ram_wea_o   = wr_acc & ~rst_i;
   assign ram_ssra_o  = rst_i;
   assign ram_addrb_o = rd_ptr_q;
   assign ram_enb_o   = rd_acc & ~rst_i;
   assign ram_ssrb_o  = rst_i;

   assign fifo_if.full     = full_q;
   assign fifo_if.afull    = afull_q;
   assign fifo_if.wr_err   = wr_err_q;
   assign fifo_if.empty    = empty_q;
   assign fifo_if.aempty   = aempty_q;
   assign fifo_if.rd_err   = rd_err_q;
   assign fifo_if.count    = count_q;
   assign fifo_if.rd_valid = rd_valid_q;
   assign fifo_if.rd_data  = ram_dob_i;
endmodule

// File: tb/tb_bram_s1_fifo_ctrl.sv
// tb/tb_bram_s1_fifo_ctrl.sv - controller plus behavioural 16Kx1 RAM against a reference queue
module tb_bram_s1_fifo_ctrl;
   localparam int DEPTH    = 16384;
   localparam int AFULL_T  = 16380;
   localparam int AEMPTY_T = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bram_s1_fifo_ctrl_if fif ();
   logic [13:0] ram_addra, ram_addrb;
   logic        ram_dia, ram_ena, ram_wea, ram_ssra, ram_enb, ram_ssrb, ram_dob;

   bram_s1_fifo_ctrl dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .fifo_if     (fif),
      .ram_addra_o (ram_addra),
      .ram_dia_o   (ram_dia),
      .ram_ena_o   (ram_ena),
      .ram_wea_o   (ram_wea),
      .ram_ssra_o  (ram_ssra),
      .ram_addrb_o (ram_addrb),
      .ram_enb_o   (ram_enb),
      .ram_ssrb_o  (ram_ssrb),
      .ram_dob_i   (ram_dob)
   );

   // 16Kx1 RAM, registered read, SSRB forces the output latch to 0
   logic mem [0:DEPTH-1];
   always @(posedge clk) begin
      if (ram_ena && ram_wea) mem[ram_addra] <= ram_dia;
      if (ram_ssrb) ram_dob <= 1'b0;
      else if (ram_enb) ram_dob <= mem[ram_addrb];
   end

   int pass_cnt  = 0;
   int total_cnt = 0;

   bit ref_q[$];
   bit m_wr_err, m_rd_err, m_valid, m_data;
   int m_wptr, m_rptr;

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; fif.wr_en = 1'b1; fif.wr_data = 1'b1; fif.rd_en = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; fif.wr_en = 1'b0; fif.rd_en = 1'b0;
      ref_q.delete();
      m_wr_err = 0; m_rd_err = 0; m_valid = 0; m_data = 0; m_wptr = 0; m_rptr = 0;
   endtask

   task automatic step(input bit we, input bit wd, input bit re);
      bit wacc, racc;
      @(negedge clk);
      fif.wr_en = we; fif.wr_data = wd; fif.rd_en = re;
      wacc = we && (ref_q.size() < DEPTH);
      racc = re && (ref_q.size() > 0);
      if (we && !wacc) m_wr_err = 1;
      if (re && !racc) m_rd_err = 1;
      m_valid = racc;
      if (racc) begin
         m_data = ref_q.pop_front();
         m_rptr = (m_rptr + 1) % DEPTH;
      end
      if (wacc) begin
         ref_q.push_back(wd);
         m_wptr = (m_wptr + 1) % DEPTH;
      end
      @(posedge clk); #1;
      fif.wr_en = 1'b0; fif.rd_en = 1'b0;
   endtask

   function automatic bit rbit();
      return ($urandom & 32'd1) != 0;
   endfunction

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; fif.wr_en = 1'b1; fif.wr_data = 1'b1; fif.rd_en = 1'b1;
      #1;
      total_cnt++; if (ram_ena !== 1'b0) $display("FAIL rst_ena got %b want 0", ram_ena); else pass_cnt++;
      total_cnt++; if (ram_wea !== 1'b0) $display("FAIL rst_wea got %b want 0", ram_wea); else pass_cnt++;
      total_cnt++; if (ram_enb !== 1'b0) $display("FAIL rst_enb got %b want 0", ram_enb); else pass_cnt++;
      total_cnt++; if (ram_ssra !== 1'b1) $display("FAIL rst_ssra got %b want 1", ram_ssra); else pass_cnt++;
      total_cnt++; if (ram_ssrb !== 1'b1) $display("FAIL rst_ssrb got %b want 1", ram_ssrb); else pass_cnt++;
      do_reset();
      total_cnt++; if (fif.count !== 15'd0) $display("FAIL rst_count got %0d want 0", fif.count); else pass_cnt++;
      total_cnt++; if (fif.empty !== 1'b1) $display("FAIL rst_empty got %b want 1", fif.empty); else pass_cnt++;
      total_cnt++; if (fif.aempty !== 1'b1) $display("FAIL rst_aempty got %b want 1", fif.aempty); else pass_cnt++;
      total_cnt++; if (fif.full !== 1'b0) $display("FAIL rst_full got %b want 0", fif.full); else pass_cnt++;
      total_cnt++; if (fif.afull !== 1'b0) $display("FAIL rst_afull got %b want 0", fif.afull); else pass_cnt++;
      total_cnt++; if (fif.rd_valid !== 1'b0) $display("FAIL rst_rd_valid got %b want 0", fif.rd_valid); else pass_cnt++;
      total_cnt++; if ({fif.wr_err, fif.rd_err} !== 2'b00) $display("FAIL rst_errs got %b want 00", {fif.wr_err, fif.rd_err}); else pass_cnt++;
      total_cnt++; if (ram_addra !== 14'd0 || ram_addrb !== 14'd0) $display("FAIL rst_ptrs got %0d/%0d want 0/0", ram_addra, ram_addrb); else pass_cnt++;
   endtask

   task automatic test_basic();
      bit exp_bits [3];
      exp_bits = '{1'b1, 1'b0, 1'b1};
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, exp_bits[i], 1'b0);
      total_cnt++; if (fif.count !== 15'd3) $display("FAIL basic_count got %0d want 3", fif.count); else pass_cnt++;
      total_cnt++; if (ram_addra !== 14'd3) $display("FAIL basic_addra got %0d want 3", ram_addra); else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 1'b1);
         total_cnt++; if (fif.rd_valid !== 1'b1) $display("FAIL basic_valid%0d got %b want 1", i, fif.rd_valid); else pass_cnt++;
         total_cnt++; if (fif.rd_data !== exp_bits[i]) $display("FAIL basic_data%0d got %b want %b", i, fif.rd_data, exp_bits[i]); else pass_cnt++;
         total_cnt++; if (fif.count !== 15'(2 - i)) $display("FAIL basic_cnt%0d got %0d want %0d", i, fif.count, 2 - i); else pass_cnt++;
      end
      step(1'b0, 1'b0, 1'b0);
      total_cnt++; if (fif.rd_valid !== 1'b0) $display("FAIL basic_valid_drop got %b want 0", fif.rd_valid); else pass_cnt++;
      total_cnt++; if (fif.empty !== 1'b1) $display("FAIL basic_empty got %b want 1", fif.empty); else pass_cnt++;
      total_cnt++; if (ram_addrb !== 14'd3) $display("FAIL basic_addrb got %0d want 3", ram_addrb); else pass_cnt++;
   endtask

   task automatic test_fill();
      int n;
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b1, rbit(), 1'b0);
         n = i + 1;
         total_cnt++; if (fif.count !== 15'(n)) $display("FAIL fill_count got %0d want %0d", fif.count, n); else pass_cnt++;
         total_cnt++; if (fif.afull !== (n >= AFULL_T)) $display("FAIL fill_afull at %0d got %b want %b", n, fif.afull, n >= AFULL_T); else pass_cnt++;
         total_cnt++; if (fif.aempty !== (n <= AEMPTY_T)) $display("FAIL fill_aempty at %0d got %b want %b", n, fif.aempty, n <= AEMPTY_T); else pass_cnt++;
         total_cnt++; if (fif.full !== (n == DEPTH)) $display("FAIL fill_full at %0d got %b want %b", n, fif.full, n == DEPTH); else pass_cnt++;
      end
      step(1'b1, 1'b1, 1'b0);
      total_cnt++; if (fif.wr_err !== 1'b1) $display("FAIL overflow_err got %b want 1", fif.wr_err); else pass_cnt++;
      total_cnt++; if (fif.count !== 15'(DEPTH)) $display("FAIL overflow_count got %0d want %0d", fif.count, DEPTH); else pass_cnt++;
      total_cnt++; if (fif.full !== 1'b1) $display("FAIL overflow_full got %b want 1", fif.full); else pass_cnt++;
   endtask

   task automatic test_full_rw();
      step(1'b1, 1'b0, 1'b1);
      total_cnt++; if (fif.count !== 15'(DEPTH - 1)) $display("FAIL fullrw_count got %0d want %0d", fif.count, DEPTH - 1); else pass_cnt++;
      total_cnt++; if (fif.full !== 1'b0) $display("FAIL fullrw_full got %b want 0", fif.full); else pass_cnt++;
      total_cnt++; if (fif.rd_valid !== 1'b1) $display("FAIL fullrw_valid got %b want 1", fif.rd_valid); else pass_cnt++;
      total_cnt++; if (fif.rd_data !== m_data) $display("FAIL fullrw_data got %b want %b", fif.rd_data, m_data); else pass_cnt++;
      total_cnt++; if (fif.wr_err !== m_wr_err) $display("FAIL fullrw_wr_err got %b want %b", fif.wr_err, m_wr_err); else pass_cnt++;
   endtask

   task automatic test_empty_rw();
      do_reset();
      step(1'b1, 1'b1, 1'b1);
      total_cnt++; if (fif.count !== 15'd1) $display("FAIL emptyrw_count got %0d want 1", fif.count); else pass_cnt++;
      total_cnt++; if (fif.rd_valid !== 1'b0) $display("FAIL emptyrw_valid got %b want 0", fif.rd_valid); else pass_cnt++;
      total_cnt++; if (fif.rd_err !== 1'b1) $display("FAIL emptyrw_rd_err got %b want 1", fif.rd_err); else pass_cnt++;
      total_cnt++; if (fif.empty !== 1'b0) $display("FAIL emptyrw_empty got %b want 0", fif.empty); else pass_cnt++;
      total_cnt++; if (fif.wr_err !== 1'b0) $display("FAIL emptyrw_wr_err got %b want 0", fif.wr_err); else pass_cnt++;
   endtask

   task automatic test_wrap();
      bit re;
      int writes;
      do_reset();
      writes = 0;
      for (int i = 0; i < 20000; i++) begin
         re = (ref_q.size() >= 8) || (ref_q.size() > 0 && ($urandom % 4) == 0);
         step(1'b1, rbit(), re);
         writes++;
         total_cnt++; if (fif.rd_valid !== m_valid) $display("FAIL wrap_valid cyc %0d got %b want %b", i, fif.rd_valid, m_valid); else pass_cnt++;
         if (m_valid) begin
            total_cnt++; if (fif.rd_data !== m_data) $display("FAIL wrap_data cyc %0d got %b want %b", i, fif.rd_data, m_data); else pass_cnt++;
         end
         total_cnt++; if (fif.count !== 15'(ref_q.size())) $display("FAIL wrap_count cyc %0d got %0d want %0d", i, fif.count, ref_q.size()); else pass_cnt++;
         total_cnt++; if (fif.aempty !== (ref_q.size() <= AEMPTY_T)) $display("FAIL wrap_aempty cyc %0d got %b want %b", i, fif.aempty, ref_q.size() <= AEMPTY_T); else pass_cnt++;
         total_cnt++; if (ram_addra !== 14'(m_wptr)) $display("FAIL wrap_addra cyc %0d got %0d want %0d", i, ram_addra, m_wptr); else pass_cnt++;
         total_cnt++; if (ram_addrb !== 14'(m_rptr)) $display("FAIL wrap_addrb cyc %0d got %0d want %0d", i, ram_addrb, m_rptr); else pass_cnt++;
      end
      total_cnt++; if (ram_addra !== 14'(writes % DEPTH)) $display("FAIL wrap_final_addra got %0d want %0d", ram_addra, writes % DEPTH); else pass_cnt++;
      total_cnt++; if (fif.rd_err !== 1'b0 || fif.wr_err !== 1'b0) $display("FAIL wrap_errs got %b%b want 00", fif.wr_err, fif.rd_err); else pass_cnt++;
   endtask

   task automatic test_reset_inflight();
      do_reset();
      step(1'b0, 1'b0, 1'b1);
      total_cnt++; if (fif.rd_err !== 1'b1) $display("FAIL inflight_pre_err got %b want 1", fif.rd_err); else pass_cnt++;
      for (int i = 0; i < 3; i++) step(1'b1, rbit(), 1'b0);
      step(1'b0, 1'b0, 1'b1);
      total_cnt++; if (fif.rd_valid !== 1'b1) $display("FAIL inflight_pre_valid got %b want 1", fif.rd_valid); else pass_cnt++;
      do_reset();
      total_cnt++; if (fif.rd_valid !== 1'b0) $display("FAIL inflight_valid got %b want 0", fif.rd_valid); else pass_cnt++;
      total_cnt++; if (fif.count !== 15'd0) $display("FAIL inflight_count got %0d want 0", fif.count); else pass_cnt++;
      total_cnt++; if (fif.empty !== 1'b1) $display("FAIL inflight_empty got %b want 1", fif.empty); else pass_cnt++;
      total_cnt++; if ({fif.wr_err, fif.rd_err} !== 2'b00) $display("FAIL inflight_errs got %b want 00", {fif.wr_err, fif.rd_err}); else pass_cnt++;
      step(1'b0, 1'b0, 1'b0);
      total_cnt++; if (fif.rd_valid !== 1'b0) $display("FAIL inflight_after got %b want 0", fif.rd_valid); else pass_cnt++;
   endtask

   initial begin
      rst = 1'b0;
      fif.wr_en = 1'b0; fif.wr_data = 1'b0; fif.rd_en = 1'b0;
      test_reset();
      test_basic();
      test_fill();
      test_full_rw();
      test_empty_rw();
      test_wrap();
      test_reset_inflight();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
